// File: rtl/obi_mem_responder.sv
// OBI responder memory: byte-enabled 64-bit word array with a fixed-latency, in-order response pipeline.
// Define OBI_MEM_WAIT_STATES_EN to insert pseudo-random grant stalls from a 16-bit LFSR.
module obi_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [63:0] addr_i,
  input  logic        we_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] wdata_i,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic          wait_state;
  logic          txn;
  logic          out_of_range;
  logic [AW-1:0] idx;
  logic [63:0]   load_data;
  logic [2:0]    addr_unused;

  logic          pipe_valid [LATENCY];
  logic          pipe_err   [LATENCY];
  logic [63:0]   pipe_data  [LATENCY];

  assign addr_unused  = addr_i[2:0];
  assign idx          = addr_i[AW+2:3];
  assign out_of_range = |addr_i[63:AW+3];
  assign gnt_o        = req_i & ~rst_i & ~wait_state;
  assign txn          = req_i & gnt_o;

`ifdef OBI_MEM_WAIT_STATES_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; low bits == 0 stalls the grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign wait_state = (lfsr[1:0] == 2'b00);
`else
  assign wait_state = 1'b0;
`endif

  // Writes and errors return zero data, so only an in-range read loads the array word
  always_comb begin
    load_data = 64'h0;
    if (txn && !we_i && !out_of_range) begin
      load_data = mem[idx];
    end else begin
      load_data = 64'h0;
    end
  end

  // Byte-enabled array update; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (txn && we_i && !out_of_range) begin
      for (int n = 0; n < 8; n++) begin
        if (be_i[n]) begin
          mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Response shift register; the last stage drives the outputs directly
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_err[i]   <= 1'b0;
        pipe_data[i]  <= 64'h0;
      end
    end else begin
      pipe_valid[0] <= txn;
      pipe_err[0]   <= txn & out_of_range;
      pipe_data[0]  <= load_data;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[LATENCY-1];
  assign err_o    = pipe_err[LATENCY-1];
  assign rdata_o  = pipe_data[LATENCY-1];

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- OBI subordinate (responder) data memory: the far end of the host-side request driver used by the pipeline's memory stage.
- Accepts req/gnt transactions, performs byte-enabled 64-bit writes and 64-bit reads on an internal word array, and returns exactly one rvalid response per granted request after a fixed latency.
- Used as the dmem/imem model in core-level simulation and as the on-chip scratchpad in the SoC top.

Parameters:
- DEPTH, 1024, number of 64-bit words; power of two, >= 2.
- LATENCY, 1, cycles from grant to rvalid; legal range 1..4.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- req_i  input  1  host request valid
- gnt_o  output 1  request accepted this cycle (combinational)
- addr_i  input  64  byte address; bits [2:0] ignored, word index = addr_i[$clog2(DEPTH)+2:3]
- we_i  input  1  1 = write, 0 = read
- be_i  input  8  byte enables, bit n covers wdata_i[8n+7:8n]
- wdata_i  input  64  write data
- rvalid_o  output 1  response valid, one-cycle pulse per response
- rdata_o  output 64  read data; 0 for writes and errors
- err_o  output 1  response error, valid with rvalid_o

Behaviour:
- Reset (rst_i high, asynchronous): rvalid_o=0, rdata_o=0, err_o=0, response pipeline flushed, wait-state LFSR seeded to 16'hACE1. Memory array contents are not reset. Transactions granted before reset produce no response.
- Grant: gnt_o = req_i & ~rst_i & ~wait_state. Without the optional feature wait_state=0, so every request is granted in its request cycle. No limit on back-to-back grants; the host has no rready and must always accept responses.
- Handshake: a transaction occurs in any cycle with req_i & gnt_o. addr_i, we_i, be_i and wdata_i are sampled only in that cycle.
- Range check: out_of_range = addr_i[63:$clog2(DEPTH)+3] != 0.
- Write (we_i=1, in range): on the grant edge, for each n with be_i[n]=1, mem[idx][8n+7:8n] <= wdata_i[8n+7:8n]. Other bytes are unchanged. be_i=0 is legal; it is a no-op write that still gets a response.
- Read (we_i=0, in range): on the grant edge, capture mem[idx] as the read value.
- Out of range, read or write: no array update; the response carries err_o=1 and rdata_o=0.
- Response pipeline: a LATENCY-stage shift register of {valid, err, data}. Stage 0 is loaded on the grant edge; otherwise stage 0 loads valid=0.
  - rvalid_o/err_o/rdata_o are driven from the last stage as registered outputs.
  - Response appears exactly LATENCY cycles after the grant cycle: LATENCY=1 gives rvalid_o high the cycle after the grant.
  - Writes respond with rdata_o=0, err_o=0.
  - When rvalid_o=0, rdata_o and err_o are 0.
- Ordering: responses are strictly in grant order. With back-to-back grants, up to LATENCY responses are in flight.
- Read-after-write: a read granted in the cycle after a write to the same word returns the post-write data.
- Simultaneous grant and response in the same cycle is normal operation; both proceed independently.
- Protocol violation: if req_i drops while gnt_o=0, nothing happens and no state changes.

Optional Feature:
- OBI_MEM_WAIT_STATES_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - wait_state = lfsr[1:0]==2'b00, which stalls roughly 25% of cycles with gnt_o=0.
  - Response latency after a grant is unchanged.
  - Used to stress host-side stall logic.
- Undefined: no LFSR logic; wait_state tied to 0.

Test Plan:
- Reset then idle: rst_i pulse mid-cycle -> rvalid_o=0, rdata_o=0, err_o=0 immediately (async); gnt_o=0 while rst_i=1.
- Write 64'h1122334455667788 be=8'hFF addr 0x40, then read addr 0x40 (LATENCY=1) -> write response rvalid with rdata 0; read rvalid exactly 1 cycle after its grant with rdata 64'h1122334455667788.
- Partial write be=8'h0C data 64'hAAAA_BBBB_CCCC_DDDD to 0x40, then read 0x44 -> 64'h11223344CCCC7788 (bits [2:0] ignored, only bytes 2..3 changed).
- LATENCY=3: back-to-back reads of 0x0, 0x8, 0x10 -> three consecutive rvalid pulses starting 3 cycles after the first grant, in order.
- Out of range, DEPTH=1024: read addr 0x2000 -> rvalid with err_o=1, rdata_o=0; write 0x2000 -> err_o=1 and no array word modified.
- Reset with 2 responses in flight (LATENCY=3) -> no rvalid after reset deasserts; then with OBI_MEM_WAIT_STATES_EN defined, 1000 random requests -> responses equal grants, and every response arrives LATENCY cycles after its grant.
